pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, output word width; only 32 is supported.
REQ-002 Parameters: RBG_SIZE, default 24, pixel colour width; only 24 is supported.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low; sampled on posedge clk.
REQ-005 colour_i  input  RBG_SIZE  pixel colour from the coordinate/colour stage.
REQ-006 valid  input  1  pixel on colour_i/first/last_x is valid.
REQ-007 first  input  1  pixel is the first of a frame.
REQ-008 last_x  input  1  pixel is the last of a line.
REQ-009 ready  output  1  packer accepts a pixel this cycle; transfer occurs when valid && ready.
REQ-010 data_o  output  DATA_WIDTH  packed output word.
REQ-011 valid_o  output  1  data_o/sop_o/eop_o are valid.
REQ-012 sop_o  output  1  word is the first word of a frame.
REQ-013 eop_o  output  1  word is the last word of a line.
REQ-014 out_ready  input  1  downstream accepts a word; transfer occurs when valid_o && out_ready.
REQ-015 desync_o  output  1  sticky flag: a frame start arrived mid-group.

Function
REQ-016 Packing: accepted pixels form a byte stream, colour_i[7:0] first, then [15:8], then [23:16]; stream byte k occupies data_o[8*(k mod 4)+7 : 8*(k mod 4)].
REQ-017 A 2-bit phase counter (0..3) tracks pixels accepted in the current 4-pixel/3-word group; it wraps 3 -> 0.
REQ-018 Words per pixel, no last_x: phase 0 -> 0 words (3 bytes held); phase 1 -> 1 word (2 bytes held); phase 2 -> 1 word (1 byte held); phase 3 -> 1 word (0 held).
REQ-019 On last_x, all held bytes are flushed; unused upper bytes of the final word are zero; phase returns to 0.
REQ-020 last_x words: phase 0 -> 1 word; phase 1 -> 2 words; phase 2 -> 2 words; phase 3 -> 1 word.
REQ-021 eop_o is 1 only on the final word of a line; sop_o is 1 only on the first word emitted after a pixel with first=1.
REQ-022 FSM states: ACCEPT and FLUSH; ACCEPT -> FLUSH when an accepted pixel produces 2 words; FLUSH -> ACCEPT when the second word is loaded into the output register.
REQ-023 ready = (state == ACCEPT) && (!valid_o || out_ready).
REQ-024 Latency: a completed word is on data_o with valid_o=1 in the cycle after the completing pixel is accepted; the FLUSH word follows in the cycle after the first word transfers.
REQ-025 While valid_o=1 and out_ready=0, data_o, sop_o, eop_o and valid_o hold stable.
REQ-026 valid_o drops to 0 after a transfer when no new word is loaded in the same cycle; back-to-back transfers sustain one word per cycle.
REQ-027 first=1 accepted with phase != 0 or held bytes present: held bytes are discarded, phase resets to 0 before packing this pixel, desync_o is set to 1.
REQ-028 first=1 and last_x=1 on the same pixel: the resulting word(s) carry sop_o on the first and eop_o on the last; a single word carries both.
REQ-029 valid=0 cycles insert no bytes and do not advance phase.

Reset
REQ-030 On reset=0 at posedge clk: valid_o=0, sop_o=0, eop_o=0, data_o=0, desync_o=0, phase=0, held bytes cleared, state=ACCEPT.
REQ-031 Reset mid-group or mid-FLUSH discards all partial data; ready is 1 in the first cycle after reset is released.

Verification
REQ-032 Pixels 0x112233(first), 0x445566, 0x778899, 0xAABBCC(last_x), out_ready=1 -> words 0x66112233 (sop), 0x88994455, 0xAABBCC77 (eop).
REQ-033 Pixels 0x112233(first), 0x445566(last_x) -> 0x66112233 (sop), then FLUSH with ready=0 for one cycle, then 0x00004455 (eop).
REQ-034 Single pixel 0xABCDEF with first=1 and last_x=1 -> one word 0x00ABCDEF, sop_o=1, eop_o=1.
REQ-035 Case REQ-032 with out_ready=0 for 5 cycles after the first word -> data_o held at 0x66112233, ready=0, then all three words appear in order with no loss.
REQ-036 Two pixels accepted, then a pixel with first=1 -> desync_o=1, partial bytes discarded, next words start at phase 0 with sop_o=1.
REQ-037 reset=0 asserted during FLUSH -> next cycle valid_o=0, ready=1, desync_o=0; a following 4-pixel line packs as in REQ-032.

Source files
------------

// File: rtl/pixel_packer.sv
// Packs a stream of 24-bit pixels into 32-bit words (4 pixels -> 3 words),
// flushing partial words at end of line, with a ready/valid handshake on both sides.
module pixel_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RBG_SIZE-1:0]   colour_i,
  input  logic                  valid,
  input  logic                  first,
  input  logic                  last_x,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  input  logic                  out_ready,
  output logic                  desync_o
);

  typedef enum logic {ACCEPT, FLUSH} state_t;

  state_t      state;
  logic [1:0]  phase;
  logic [23:0] held;
  logic [31:0] flush_word;
  logic        sop_pend;

  logic        take;
  logic [1:0]  eff_phase;
  logic [1:0]  n_held;
  logic [23:0] eff_held;
  logic [47:0] stream;
  logic [15:0] rem;
  logic [23:0] next_held;
  logic        emit_one;
  logic        two_words;
  logic        sop_now;

  assign ready = (state == ACCEPT) && (!valid_o || out_ready);
  assign take  = valid && ready;

  // A frame start restarts the group: held bytes are dropped before this pixel is packed.
  assign eff_phase = first ? 2'd0 : phase;
  assign eff_held  = first ? 24'd0 : held;
  assign n_held    = 2'd0 - eff_phase;

  // Held bytes sit at the bottom of the stream, the new pixel's bytes follow them.
  assign stream    = ({24'd0, colour_i} << {n_held, 3'b000}) | {24'd0, eff_held};
  assign rem       = stream[47:32];
  assign next_held = (eff_phase == 2'd0) ? stream[23:0] : {8'd0, rem};
  assign emit_one  = (eff_phase != 2'd0) || last_x;
  assign two_words = last_x && ((eff_phase == 2'd1) || (eff_phase == 2'd2));
  assign sop_now   = sop_pend || first;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ACCEPT;
      phase      <= 2'd0;
      held       <= 24'd0;
      flush_word <= 32'd0;
      sop_pend   <= 1'b0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      desync_o   <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (take) begin
            if (first && (phase != 2'd0))
              desync_o <= 1'b1;
            phase <= last_x ? 2'd0 : eff_phase + 2'd1;
            held  <= last_x ? 24'd0 : next_held;
            if (emit_one) begin
              data_o   <= stream[31:0];
              valid_o  <= 1'b1;
              sop_o    <= sop_now;
              eop_o    <= last_x && !two_words;
              sop_pend <= 1'b0;
            end else begin
              sop_pend <= sop_now;
              if (out_ready) begin
                valid_o <= 1'b0;
                sop_o   <= 1'b0;
                eop_o   <= 1'b0;
              end
            end
            if (two_words) begin
              flush_word <= {16'd0, rem};
              state      <= FLUSH;
            end
          end else if (out_ready) begin
            valid_o <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
          end
        end
        FLUSH: begin
          if (!valid_o || out_ready) begin
            data_o  <= flush_word;
            valid_o <= 1'b1;
            sop_o   <= 1'b0;
            eop_o   <= 1'b1;
            state   <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer; expected words are queued as pixels are
// driven and checked in order whenever the DUT transfers a word.
module tb_pixel_packer;

  logic        clk;
  logic        reset;
  logic [23:0] colour_i;
  logic        valid;
  logic        first;
  logic        last_x;
  logic        ready;
  logic [31:0] data_o;
  logic        valid_o;
  logic        sop_o;
  logic        eop_o;
  logic        out_ready;
  logic        desync_o;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pixel_packer #(.DATA_WIDTH(32), .RBG_SIZE(24)) dut (
    .clk(clk), .reset(reset), .colour_i(colour_i), .valid(valid),
    .first(first), .last_x(last_x), .ready(ready), .data_o(data_o),
    .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .out_ready(out_ready), .desync_o(desync_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic s, input logic e);
    exp_t x;
    x.data = d;
    x.sop  = s;
    x.eop  = e;
    sb.push_back(x);
  endtask

  // Called at the negative edge: a word visible with out_ready high transfers at the next edge.
  task automatic check_output();
    exp_t e;
    if (valid_o && out_ready) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("[TB] FAIL unexpected_word observed=%08h expected=none", data_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("word_data", data_o, e.data);
        check("word_sop", {31'd0, sop_o}, {31'd0, e.sop});
        check("word_eop", {31'd0, eop_o}, {31'd0, e.eop});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [23:0] c, input logic f, input logic l);
    logic got;
    got      = 1'b0;
    colour_i = c;
    first    = f;
    last_x   = l;
    valid    = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = ready;
      check_output();
      @(posedge clk);
      #1;
    end
    valid  = 1'b0;
    first  = 1'b0;
    last_x = 1'b0;
    n_checks++;
    assert (got) else begin
      n_fail++;
      $error("[TB] FAIL accept_timeout observed=ready_low expected=accepted pixel %06h", c);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) tick();
    check("sb_empty", sb.size(), 32'd0);
    check("idle_valid_o", {31'd0, valid_o}, 32'd0);
  endtask

  task automatic four_pixel_line();
    push_word(32'h66112233, 1'b1, 1'b0);
    push_word(32'h88994455, 1'b0, 1'b0);
    push_word(32'hAABBCC77, 1'b0, 1'b1);
    apply_stimulus(24'h112233, 1'b1, 1'b0);
    tick();
    apply_stimulus(24'h445566, 1'b0, 1'b0);
    apply_stimulus(24'h778899, 1'b0, 1'b0);
    tick();
    tick();
    apply_stimulus(24'hAABBCC, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    reset     = 1'b0;
    colour_i  = 24'd0;
    valid     = 1'b0;
    first     = 1'b0;
    last_x    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_sop_o", {31'd0, sop_o}, 32'd0);
    check("rst_eop_o", {31'd0, eop_o}, 32'd0);
    check("rst_desync_o", {31'd0, desync_o}, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, ready}, 32'd1);

    // Full group with idle gaps between pixels.
    four_pixel_line();

    // Two-pixel line: second pixel needs a flush word.
    push_word(32'h66112233, 1'b1, 1'b0);
    push_word(32'h00004455, 1'b0, 1'b1);
    apply_stimulus(24'h112233, 1'b1, 1'b0);
    apply_stimulus(24'h445566, 1'b0, 1'b1);
    check("flush_ready_low", {31'd0, ready}, 32'd0);
    drain();

    // Single pixel that both starts the frame and ends the line.
    push_word(32'h00ABCDEF, 1'b1, 1'b1);
    apply_stimulus(24'hABCDEF, 1'b1, 1'b1);
    drain();

    // Downstream stall after the first word.
    out_ready = 1'b0;
    push_word(32'h66112233, 1'b1, 1'b0);
    push_word(32'h88994455, 1'b0, 1'b0);
    push_word(32'hAABBCC77, 1'b0, 1'b1);
    apply_stimulus(24'h112233, 1'b1, 1'b0);
    apply_stimulus(24'h445566, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_data", data_o, 32'h66112233);
      check("stall_valid", {31'd0, valid_o}, 32'd1);
      check("stall_ready", {31'd0, ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    apply_stimulus(24'h778899, 1'b0, 1'b0);
    apply_stimulus(24'hAABBCC, 1'b0, 1'b1);
    drain();
    check("no_desync_yet", {31'd0, desync_o}, 32'd0);

    // Frame start arriving mid-group.
    push_word(32'h66112233, 1'b1, 1'b0);
    push_word(32'h06010203, 1'b1, 1'b0);
    push_word(32'h00000405, 1'b0, 1'b1);
    apply_stimulus(24'h112233, 1'b1, 1'b0);
    apply_stimulus(24'h445566, 1'b0, 1'b0);
    apply_stimulus(24'h010203, 1'b1, 1'b0);
    check("desync_set", {31'd0, desync_o}, 32'd1);
    apply_stimulus(24'h040506, 1'b0, 1'b1);
    drain();

    // Reset while a flush word is pending.
    apply_stimulus(24'h112233, 1'b1, 1'b0);
    out_ready = 1'b0;
    apply_stimulus(24'h445566, 1'b0, 1'b1);
    check("pre_rst_flush_ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_rst_valid_o", {31'd0, valid_o}, 32'd0);
    reset = 1'b1;
    tick();
    check("rel_ready", {31'd0, ready}, 32'd1);
    check("rel_valid_o", {31'd0, valid_o}, 32'd0);
    check("rel_desync_o", {31'd0, desync_o}, 32'd0);
    out_ready = 1'b1;
    four_pixel_line();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
